// File: rtl/hist2d_iq_binner.sv
// Bins signed I/Q sample pairs into (i,q) coordinates using two parallel restoring dividers.
// Latency: bin_valid 27 cycles after accept, then GAP_CYCLES idle; sample_ready only while waiting for a sample.
// Optional HIST2D_BINNER_SKIP_OOR_EN: drop out-of-range samples instead of clamping them to edge bins.
module hist2d_iq_binner #(
  parameter int SAMPLE_W   = 16,
  parameter int BIN_W      = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic                clk100,
  input  logic                reset_n,
  input  logic                arm,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic [SAMPLE_W-1:0] q_sample,
  input  logic [SAMPLE_W-1:0] i_min,
  input  logic [SAMPLE_W-1:0] i_max,
  input  logic [SAMPLE_W-1:0] q_min,
  input  logic [SAMPLE_W-1:0] q_max,
  input  logic [BIN_W-1:0]    i_bin_num,
  input  logic [BIN_W-1:0]    q_bin_num,
  input  logic [15:0]         num_data_pts,
  output logic                bin_valid,
  output logic [BIN_W-1:0]    i_bin_coord,
  output logic [BIN_W-1:0]    q_bin_coord,
  output logic [15:0]         pts_count,
  output logic [15:0]         oor_count,
  output logic                acq_done,
  output logic                cfg_err
);
  localparam int OFF_W = SAMPLE_W + 1;
  localparam int NUM_W = OFF_W + BIN_W;
  localparam int REM_W = OFF_W + 1;
  localparam int CNT_W = $clog2(NUM_W + GAP_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, WAIT_SAMPLE, LOAD, DIVIDE, EMIT, GAP, DONE} state_t;

  function automatic logic [OFF_W-1:0] offset_f(input logic [SAMPLE_W-1:0] s,
                                                input logic [SAMPLE_W-1:0] mn,
                                                input logic [SAMPLE_W-1:0] mx);
    logic signed [OFF_W-1:0] se, mne, mxe, c;
    se  = {s[SAMPLE_W-1], s};
    mne = {mn[SAMPLE_W-1], mn};
    mxe = {mx[SAMPLE_W-1], mx};
    if (se < mne)      c = mne;
    else if (se > mxe) c = mxe;
    else               c = se;
    return c - mne;
  endfunction

  function automatic logic oor_f(input logic [SAMPLE_W-1:0] s,
                                 input logic [SAMPLE_W-1:0] mn,
                                 input logic [SAMPLE_W-1:0] mx);
    return ($signed(s) < $signed(mn)) || ($signed(s) > $signed(mx));
  endfunction

  function automatic logic [OFF_W-1:0] den_f(input logic [SAMPLE_W-1:0] mn,
                                             input logic [SAMPLE_W-1:0] mx);
    return {mx[SAMPLE_W-1], mx} - {mn[SAMPLE_W-1], mn};
  endfunction

  // One restoring step: dividend bits shift out of quo's MSB while quotient bits shift in at the LSB.
  function automatic logic [REM_W+NUM_W-1:0] div_step(input logic [REM_W-1:0] rem,
                                                      input logic [NUM_W-1:0] quo,
                                                      input logic [OFF_W-1:0] den);
    logic [REM_W-1:0] sh;
    logic             qbit;
    sh   = {rem[REM_W-2:0], quo[NUM_W-1]};
    qbit = (sh >= {1'b0, den});
    if (qbit) sh = sh - {1'b0, den};
    return {sh, quo[NUM_W-2:0], qbit};
  endfunction

  function automatic logic [BIN_W-1:0] coord_f(input logic [NUM_W-1:0] quo,
                                               input logic [BIN_W-1:0] bn,
                                               input logic             err);
    if (err || bn == '0)      return '0;
    if (quo >= NUM_W'(bn))    return bn - 1'b1;
    return quo[BIN_W-1:0];
  endfunction

  state_t             state_q, state_d;
  logic [SAMPLE_W-1:0] i_s_q, i_s_d, q_s_q, q_s_d;
  logic [SAMPLE_W-1:0] i_min_q, i_min_d, i_max_q, i_max_d, q_min_q, q_min_d, q_max_q, q_max_d;
  logic [REM_W-1:0]    i_rem_q, i_rem_d, q_rem_q, q_rem_d;
  logic [NUM_W-1:0]    i_quo_q, i_quo_d, q_quo_q, q_quo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                bin_valid_q, bin_valid_d, done_q, done_d;
  logic [BIN_W-1:0]    i_coord_q, i_coord_d, q_coord_q, q_coord_d;
  logic [15:0]         pts_q, pts_d, oor_q, oor_d;
  logic                i_oor, q_oor;

  assign i_oor = oor_f(i_s_q, i_min_q, i_max_q);
  assign q_oor = oor_f(q_s_q, q_min_q, q_max_q);

  always_comb begin
    state_d     = state_q;
    i_s_d       = i_s_q;    q_s_d   = q_s_q;
    i_min_d     = i_min_q;  i_max_d = i_max_q;
    q_min_d     = q_min_q;  q_max_d = q_max_q;
    i_rem_d     = i_rem_q;  q_rem_d = q_rem_q;
    i_quo_d     = i_quo_q;  q_quo_d = q_quo_q;
    cnt_d       = cnt_q;
    bin_valid_d = 1'b0;
    i_coord_d   = i_coord_q;
    q_coord_d   = q_coord_q;
    pts_d       = pts_q;
    oor_d       = oor_q;
    done_d      = done_q;
    case (state_q)
      IDLE, DONE: if (arm) begin
        pts_d  = '0;
        oor_d  = '0;
        done_d = (num_data_pts == 16'd0);
        state_d = (num_data_pts == 16'd0) ? DONE : WAIT_SAMPLE;
      end
      WAIT_SAMPLE: if (sample_valid) begin
        i_s_d   = i_sample;  q_s_d   = q_sample;
        i_min_d = i_min;     i_max_d = i_max;
        q_min_d = q_min;     q_max_d = q_max;
        state_d = LOAD;
      end
      LOAD: begin
        i_quo_d = NUM_W'(offset_f(i_s_q, i_min_q, i_max_q)) * NUM_W'(i_bin_num);
        q_quo_d = NUM_W'(offset_f(q_s_q, q_min_q, q_max_q)) * NUM_W'(q_bin_num);
        i_rem_d = '0;
        q_rem_d = '0;
        cnt_d   = '0;
        if ((i_oor || q_oor) && oor_q != 16'hFFFF) oor_d = oor_q + 16'd1;
`ifdef HIST2D_BINNER_SKIP_OOR_EN
        state_d = (i_oor || q_oor) ? WAIT_SAMPLE : DIVIDE;
`else
        state_d = DIVIDE;
`endif
      end
      DIVIDE: begin
        {i_rem_d, i_quo_d} = div_step(i_rem_q, i_quo_q, den_f(i_min_q, i_max_q));
        {q_rem_d, q_quo_d} = div_step(q_rem_q, q_quo_q, den_f(q_min_q, q_max_q));
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NUM_W - 1)) state_d = EMIT;
      end
      EMIT: begin
        bin_valid_d = 1'b1;
        i_coord_d   = coord_f(i_quo_q, i_bin_num, $signed(i_max_q) <= $signed(i_min_q));
        q_coord_d   = coord_f(q_quo_q, q_bin_num, $signed(q_max_q) <= $signed(q_min_q));
        if (pts_q < num_data_pts) pts_d = pts_q + 16'd1;
        cnt_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          if (pts_q >= num_data_pts) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT_SAMPLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (!reset_n) begin
      state_q <= IDLE;
      i_s_q <= '0;  q_s_q <= '0;
      i_min_q <= '0;  i_max_q <= '0;  q_min_q <= '0;  q_max_q <= '0;
      i_rem_q <= '0;  q_rem_q <= '0;  i_quo_q <= '0;  q_quo_q <= '0;
      cnt_q <= '0;
      bin_valid_q <= 1'b0;
      i_coord_q <= '0;  q_coord_q <= '0;
      pts_q <= '0;  oor_q <= '0;  done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_s_q <= i_s_d;  q_s_q <= q_s_d;
      i_min_q <= i_min_d;  i_max_q <= i_max_d;  q_min_q <= q_min_d;  q_max_q <= q_max_d;
      i_rem_q <= i_rem_d;  q_rem_q <= q_rem_d;  i_quo_q <= i_quo_d;  q_quo_q <= q_quo_d;
      cnt_q <= cnt_d;
      bin_valid_q <= bin_valid_d;
      i_coord_q <= i_coord_d;  q_coord_q <= q_coord_d;
      pts_q <= pts_d;  oor_q <= oor_d;  done_q <= done_d;
    end
  end

  assign sample_ready = (state_q == WAIT_SAMPLE);
  assign bin_valid    = bin_valid_q;
  assign i_bin_coord  = i_coord_q;
  assign q_bin_coord  = q_coord_q;
  assign pts_count    = pts_q;
  assign oor_count    = oor_q;
  assign acq_done     = done_q;
  assign cfg_err      = ($signed(i_max) <= $signed(i_min)) || ($signed(q_max) <= $signed(q_min));
endmodule

// File: tb/tb_hist2d_iq_binner.sv
// Self-checking bench for hist2d_iq_binner: directed and randomized samples against an arithmetic bin model.
module tb_hist2d_iq_binner;
  localparam int GAP = 4;
`ifdef HIST2D_BINNER_SKIP_OOR_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk100 = 1'b0;
  logic        reset_n = 1'b0;
  logic        arm = 1'b0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [15:0] i_sample = '0, q_sample = '0;
  logic [15:0] i_min = '0, i_max = '0, q_min = '0, q_max = '0;
  logic [7:0]  i_bin_num = '0, q_bin_num = '0;
  logic [15:0] num_data_pts = '0;
  logic        bin_valid;
  logic [7:0]  i_bin_coord, q_bin_coord;
  logic [15:0] pts_count, oor_count;
  logic        acq_done, cfg_err;

  int errors = 0;
  int checks = 0;

  always #5 clk100 = ~clk100;

  hist2d_iq_binner #(.SAMPLE_W(16), .BIN_W(8), .GAP_CYCLES(GAP)) dut (
    .clk100(clk100), .reset_n(reset_n), .arm(arm),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .i_sample(i_sample), .q_sample(q_sample),
    .i_min(i_min), .i_max(i_max), .q_min(q_min), .q_max(q_max),
    .i_bin_num(i_bin_num), .q_bin_num(q_bin_num), .num_data_pts(num_data_pts),
    .bin_valid(bin_valid), .i_bin_coord(i_bin_coord), .q_bin_coord(q_bin_coord),
    .pts_count(pts_count), .oor_count(oor_count), .acq_done(acq_done), .cfg_err(cfg_err)
  );

  // Reference: clamp into range, scale offset by bin count over the span, floor, cap at the last bin.
  function automatic int exp_coord(input int s, input int mn, input int mx, input int bn);
    longint c;
    if (mx <= mn || bn == 0) return 0;
    c = (s < mn) ? mn : (s > mx) ? mx : s;
    c = ((c - mn) * bn) / (mx - mn);
    if (c > bn - 1) c = bn - 1;
    return int'(c);
  endfunction

  function automatic bit is_oor(input int s, input int mn, input int mx);
    return (s < mn) || (s > mx);
  endfunction

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; arm = 1'b0; sample_valid = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic set_cfg(input int imn, input int imx, input int qmn, input int qmx,
                         input int ibn, input int qbn);
    i_min = 16'(imn); i_max = 16'(imx); q_min = 16'(qmn); q_max = 16'(qmx);
    i_bin_num = 8'(ibn); q_bin_num = 8'(qbn);
  endtask

  task automatic do_arm(input int n);
    num_data_pts = 16'(n);
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic send_sample(input int is, input int qs, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (sample_ready) begin ok = 1'b1; break; end
      tick();
    end
    if (ok) begin
      i_sample = 16'(is); q_sample = 16'(qs);
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
    end
  endtask

  task automatic wait_bin(input int limit, output int lat);
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (bin_valid) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    set_cfg(-1000, 1000, -1000, 1000, 10, 10);
    reset_n = 1'b0;
    tick();
    checks++;
    if ({bin_valid, sample_ready, acq_done, i_bin_coord, q_bin_coord, pts_count, oor_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {bin_valid, sample_ready, acq_done, i_bin_coord, q_bin_coord, pts_count, oor_count});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_center();
    bit ok; int lat;
    apply_reset();
    set_cfg(-1000, 1000, -1000, 1000, 10, 10);
    do_arm(10);
    send_sample(0, -1000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL center_accept: got %0d required 1", ok); end
    wait_bin(60, lat);
    checks++; if (lat != 27) begin errors++; $display("FAIL center_latency: got %0d required 27", lat); end
    checks++; if (i_bin_coord !== 8'd5) begin errors++; $display("FAIL center_i: got %0d required 5", i_bin_coord); end
    checks++; if (q_bin_coord !== 8'd0) begin errors++; $display("FAIL center_q: got %0d required 0", q_bin_coord); end
    checks++; if (pts_count !== 16'd1) begin errors++; $display("FAIL center_pts: got %0d required 1", pts_count); end
    tick();
    checks++; if (bin_valid !== 1'b0) begin errors++; $display("FAIL center_pulse_width: got %0d required 0", bin_valid); end
    checks++; if (i_bin_coord !== 8'd5) begin errors++; $display("FAIL center_hold: got %0d required 5", i_bin_coord); end
  endtask

  task automatic test_max_edge();
    bit ok; int lat;
    apply_reset();
    set_cfg(-1000, 1000, -1000, 1000, 10, 10);
    do_arm(10);
    send_sample(999, 1000, ok);
    wait_bin(60, lat);
    checks++; if (lat != 27) begin errors++; $display("FAIL edge_latency: got %0d required 27", lat); end
    checks++; if (i_bin_coord !== 8'd9) begin errors++; $display("FAIL edge_i: got %0d required 9", i_bin_coord); end
    checks++; if (q_bin_coord !== 8'd9) begin errors++; $display("FAIL edge_q: got %0d required 9", q_bin_coord); end
    checks++; if (oor_count !== 16'd0) begin errors++; $display("FAIL edge_oor: got %0d required 0", oor_count); end
  endtask

  task automatic test_oor();
    bit ok; int lat;
    apply_reset();
    set_cfg(-1000, 1000, -1000, 1000, 10, 10);
    do_arm(10);
    send_sample(1500, -2000, ok);
    wait_bin(40, lat);
`ifdef HIST2D_BINNER_SKIP_OOR_EN
    checks++; if (lat != -1) begin errors++; $display("FAIL oor_dropped: got latency %0d required none", lat); end
    checks++; if (pts_count !== 16'd0) begin errors++; $display("FAIL oor_pts: got %0d required 0", pts_count); end
`else
    checks++; if (lat != 27) begin errors++; $display("FAIL oor_latency: got %0d required 27", lat); end
    checks++; if ({i_bin_coord, q_bin_coord} !== {8'd9, 8'd0}) begin
      errors++; $display("FAIL oor_coords: got (%0d,%0d) required (9,0)", i_bin_coord, q_bin_coord);
    end
    checks++; if (pts_count !== 16'd1) begin errors++; $display("FAIL oor_pts: got %0d required 1", pts_count); end
`endif
    checks++; if (oor_count !== 16'd1) begin errors++; $display("FAIL oor_count: got %0d required 1", oor_count); end
  endtask

  task automatic test_back_to_back();
    int qi[$], qq[$];
    int acc_edge, last_bin, pulses, accepts, ei, eq;
    bit acc;
    apply_reset();
    set_cfg(-1000, 1000, -500, 700, 10, 37);
    do_arm(5);
    i_sample = 16'(int'($urandom_range(2000)) - 1000);
    q_sample = 16'(int'($urandom_range(1200)) - 500);
    sample_valid = 1'b1;
    acc_edge = 0; last_bin = -100; pulses = 0; accepts = 0;
    for (int c = 0; c < 300; c++) begin
      acc = sample_valid && sample_ready;
      if (acc) begin
        accepts++;
        qi.push_back(exp_coord(int'($signed(i_sample)), -1000, 1000, 10));
        qq.push_back(exp_coord(int'($signed(q_sample)), -500, 700, 37));
        if (pulses > 0) begin
          checks++;
          if (c + 1 - last_bin < GAP + 1) begin
            errors++; $display("FAIL b2b_gap: got %0d cycles required >= %0d", c + 1 - last_bin, GAP + 1);
          end
        end
        acc_edge = c + 1;
      end
      tick();
      if (acc) begin
        i_sample = 16'(int'($urandom_range(2000)) - 1000);
        q_sample = 16'(int'($urandom_range(1200)) - 500);
      end
      if (bin_valid) begin
        pulses++;
        last_bin = c + 1;
        ei = (qi.size() > 0) ? qi.pop_front() : -1;
        eq = (qq.size() > 0) ? qq.pop_front() : -1;
        checks++;
        if (last_bin - acc_edge != 27) begin
          errors++; $display("FAIL b2b_latency: got %0d required 27", last_bin - acc_edge);
        end
        checks++;
        if (int'(i_bin_coord) != ei || int'(q_bin_coord) != eq) begin
          errors++; $display("FAIL b2b_coords: got (%0d,%0d) required (%0d,%0d)", i_bin_coord, q_bin_coord, ei, eq);
        end
      end
    end
    sample_valid = 1'b0;
    checks++; if (pulses != 5) begin errors++; $display("FAIL b2b_pulses: got %0d required 5", pulses); end
    checks++; if (accepts != 5) begin errors++; $display("FAIL b2b_accepts: got %0d required 5", accepts); end
    checks++; if (acq_done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %0d required 1", acq_done); end
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready: got %0d required 0", sample_ready); end
    checks++; if (pts_count !== 16'd5) begin errors++; $display("FAIL b2b_pts: got %0d required 5", pts_count); end
    do_arm(3);
    checks++; if (pts_count !== 16'd0) begin errors++; $display("FAIL rearm_pts: got %0d required 0", pts_count); end
    checks++; if (acq_done !== 1'b0) begin errors++; $display("FAIL rearm_done: got %0d required 0", acq_done); end
  endtask

  task automatic test_reset_mid_divide();
    bit ok; int lat;
    apply_reset();
    set_cfg(-1000, 1000, -1000, 1000, 10, 10);
    do_arm(4);
    send_sample(300, 700, ok);
    wait_bin(60, lat);
    send_sample(-700, 100, ok);
    repeat (10) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if ({bin_valid, sample_ready, acq_done, i_bin_coord, q_bin_coord, pts_count, oor_count} !== '0) begin
      errors++;
      $display("FAIL middiv_outputs: got %h required 0",
               {bin_valid, sample_ready, acq_done, i_bin_coord, q_bin_coord, pts_count, oor_count});
    end
    wait_bin(40, lat);
    checks++; if (lat != -1) begin errors++; $display("FAIL middiv_no_event: got latency %0d required none", lat); end
    do_arm(4);
    send_sample(0, -1000, ok);
    wait_bin(60, lat);
    checks++; if (lat != 27) begin errors++; $display("FAIL middiv_rearm_latency: got %0d required 27", lat); end
    checks++; if ({i_bin_coord, q_bin_coord} !== {8'd5, 8'd0}) begin
      errors++; $display("FAIL middiv_rearm_coords: got (%0d,%0d) required (5,0)", i_bin_coord, q_bin_coord);
    end
  endtask

  task automatic test_cfg_err();
    bit ok; int lat;
    apply_reset();
    set_cfg(0, 0, -1000, 1000, 10, 10);
    #1;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_i: got %0d required 1", cfg_err); end
    do_arm(2);
    send_sample(0, 0, ok);
    wait_bin(60, lat);
    checks++; if (lat != 27) begin errors++; $display("FAIL cfg_latency: got %0d required 27", lat); end
    checks++; if (i_bin_coord !== 8'd0) begin errors++; $display("FAIL cfg_i_coord: got %0d required 0", i_bin_coord); end
    checks++; if (q_bin_coord !== 8'd5) begin errors++; $display("FAIL cfg_q_coord: got %0d required 5", q_bin_coord); end
    set_cfg(-1000, 1000, -1000, 1000, 10, 10);
    #1;
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_clear: got %0d required 0", cfg_err); end
    set_cfg(-1000, 1000, 50, -50, 10, 10);
    #1;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_q: got %0d required 1", cfg_err); end
  endtask

  task automatic test_zero_pts();
    int pulses;
    apply_reset();
    set_cfg(-1000, 1000, -1000, 1000, 10, 10);
    do_arm(0);
    checks++; if (acq_done !== 1'b1) begin errors++; $display("FAIL zero_done: got %0d required 1", acq_done); end
    checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL zero_ready: got %0d required 0", sample_ready); end
    sample_valid = 1'b1;
    pulses = 0;
    repeat (35) begin
      tick();
      if (bin_valid || sample_ready) pulses++;
    end
    sample_valid = 1'b0;
    checks++; if (pulses != 0) begin errors++; $display("FAIL zero_activity: got %0d active cycles required 0", pulses); end
    checks++; if (pts_count !== 16'd0) begin errors++; $display("FAIL zero_pts: got %0d required 0", pts_count); end
  endtask

  task automatic test_random();
    bit ok, oor, emit;
    int lat, imn, imx, qmn, qmx, ibn, qbn, is, qs, exp_pts, exp_oor, n;
    apply_reset();
    for (int a = 0; a < 3; a++) begin
      imn = -int'($urandom_range(20000)); imx = imn + 1 + int'($urandom_range(30000));
      qmn = -int'($urandom_range(20000)); qmx = qmn + 1 + int'($urandom_range(30000));
      ibn = int'($urandom_range(255));    qbn = 1 + int'($urandom_range(254));
      set_cfg(imn, imx, qmn, qmx, ibn, qbn);
      do_arm(4);
      if (a > 0) begin
        checks++;
        if ({pts_count, oor_count, acq_done} !== '0) begin
          errors++; $display("FAIL rand_rearm_clear: got pts=%0d oor=%0d done=%0d required 0", pts_count, oor_count, acq_done);
        end
      end
      exp_pts = 0; exp_oor = 0; n = 0;
      while (exp_pts < 4 && n < 12) begin
        is = (n == 0) ? imx + 1 + int'($urandom_range(200))
                      : imn - 300 + int'($urandom_range(32'(imx - imn + 600)));
        qs = qmn - 300 + int'($urandom_range(32'(qmx - qmn + 600)));
        oor  = is_oor(is, imn, imx) || is_oor(qs, qmn, qmx);
        emit = !(SKIP && oor);
        send_sample(is, qs, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rand_accept: got %0d required 1", ok); end
        wait_bin(emit ? 40 : 35, lat);
        if (oor) exp_oor++;
        if (emit) begin
          exp_pts++;
          checks++; if (lat != 27) begin errors++; $display("FAIL rand_latency: got %0d required 27", lat); end
          checks++;
          if (int'(i_bin_coord) != exp_coord(is, imn, imx, ibn) || int'(q_bin_coord) != exp_coord(qs, qmn, qmx, qbn)) begin
            errors++;
            $display("FAIL rand_coords: got (%0d,%0d) required (%0d,%0d) for I=%0d Q=%0d", i_bin_coord, q_bin_coord,
                     exp_coord(is, imn, imx, ibn), exp_coord(qs, qmn, qmx, qbn), is, qs);
          end
        end else begin
          checks++; if (lat != -1) begin errors++; $display("FAIL rand_dropped: got latency %0d required none", lat); end
        end
        n++;
      end
      repeat (GAP + 1) tick();
      checks++; if (acq_done !== 1'b1) begin errors++; $display("FAIL rand_done: got %0d required 1", acq_done); end
      checks++; if (int'(pts_count) != exp_pts) begin errors++; $display("FAIL rand_pts: got %0d required %0d", pts_count, exp_pts); end
      checks++; if (int'(oor_count) != exp_oor) begin errors++; $display("FAIL rand_oor: got %0d required %0d", oor_count, exp_oor); end
    end
  endtask

  initial begin
    test_reset();
    test_center();
    test_max_edge();
    test_oor();
    test_back_to_back();
    test_reset_mid_divide();
    test_cfg_err();
    test_zero_pts();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
